// File: rtl/tdm_demux_1_n.sv
// TDM receive demultiplexer: steers slot words of one serial lane into per-channel registers.
// Optional frame counter output enabled by defining TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux_1_n #(
   parameter int N_CH = 4,
   parameter int W    = 8,
   localparam int CW  = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      din,
   input  logic              din_valid,
   input  logic              frame_sync,
   output logic [N_CH*W-1:0] ch_data,
   output logic [N_CH-1:0]   ch_valid,
   output logic              frame_done,
   output logic              sync_err,
`ifdef TDM_DEMUX_FRAME_CNT_EN
   output logic [15:0]       frame_cnt,
`endif
   output logic [CW-1:0]     slot
);

   typedef enum logic {
      HUNT,
      LOCK
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

   state_t        state;
   logic          take;
   logic          resync;
   logic [CW-1:0] tgt;
   logic [CW-1:0] nxt;

   // A sync word always lands in slot 0; otherwise the flywheel position is used.
   always_comb begin
      take   = 1'b0;
      resync = 1'b0;
      tgt    = slot;
      nxt    = slot;
      if (din_valid) begin
         take   = frame_sync || (state == LOCK);
         resync = frame_sync && (state == LOCK) && (slot != '0);
         tgt    = frame_sync ? '0 : slot;
         nxt    = (tgt == LAST) ? '0 : tgt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         ch_data    <= '0;
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         slot       <= '0;
      end else begin
         ch_valid   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         if (take) begin
            state                      <= LOCK;
            ch_data[int'(tgt)*W +: W]  <= din;
            ch_valid[tgt]              <= 1'b1;
            frame_done                 <= (tgt == LAST);
            sync_err                   <= resync;
            slot                       <= nxt;
         end
      end
   end

`ifdef TDM_DEMUX_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (take && resync) begin
         frame_cnt <= '0;
      end else if (take && (tgt == LAST)) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tdm_demux_1_n.sv
// Directed-vector bench for tdm_demux_1_n (N_CH=4, W=8).
// Frame counter checks run only when TDM_DEMUX_FRAME_CNT_EN is defined.
module tb_tdm_demux_1_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        frame_sync;
   logic [31:0] ch_data;
   logic [3:0]  ch_valid;
   logic        frame_done;
   logic        sync_err;
   logic [1:0]  slot;
`ifdef TDM_DEMUX_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   tdm_demux_1_n #(.N_CH(4), .W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err),
`ifdef TDM_DEMUX_FRAME_CNT_EN
      .frame_cnt  (frame_cnt),
`endif
      .slot       (slot)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        v;
      logic        s;
      logic [7:0]  d;
      logic [31:0] cd;
      logic [3:0]  cv;
      logic        fd;
      logic        se;
      logic [1:0]  sl;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, v, s, input logic [7:0] d,
                      input logic [31:0] cd, input logic [3:0] cv,
                      input logic fd, se, input logic [1:0] sl);
      vec_t t;
      t.r = r; t.v = v; t.s = s; t.d = d;
      t.cd = cd; t.cv = cv; t.fd = fd; t.se = se; t.sl = sl;
      tv.push_back(t);
   endtask

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, v, s, input logic [7:0] d);
      @(negedge clk);
      rst = r; din_valid = v; frame_sync = s; din = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;

      // reset and HUNT drop
      add(1, 0, 0, 8'h00, 32'h0, 4'b0000, 0, 0, 0);
      add(1, 0, 0, 8'h00, 32'h0, 4'b0000, 0, 0, 0);
      add(0, 1, 0, 8'hAA, 32'h0, 4'b0000, 0, 0, 0);
      add(0, 1, 0, 8'hAA, 32'h0, 4'b0000, 0, 0, 0);
      add(0, 1, 0, 8'hAA, 32'h0, 4'b0000, 0, 0, 0);
      // first synced frame
      add(0, 1, 1, 8'h11, 32'h00000011, 4'b0001, 0, 0, 1);
      add(0, 1, 0, 8'h22, 32'h00002211, 4'b0010, 0, 0, 2);
      add(0, 1, 0, 8'h33, 32'h00332211, 4'b0100, 0, 0, 3);
      add(0, 1, 0, 8'h44, 32'h44332211, 4'b1000, 1, 0, 0);
      // flywheel frame
      add(0, 1, 0, 8'h55, 32'h44332255, 4'b0001, 0, 0, 1);
      add(0, 1, 0, 8'h66, 32'h44336655, 4'b0010, 0, 0, 2);
      add(0, 1, 0, 8'h77, 32'h44776655, 4'b0100, 0, 0, 3);
      add(0, 1, 0, 8'h88, 32'h88776655, 4'b1000, 1, 0, 0);
      // sync without valid is ignored
      add(0, 0, 1, 8'h12, 32'h88776655, 4'b0000, 0, 0, 0);
      add(0, 1, 0, 8'h01, 32'h88776601, 4'b0001, 0, 0, 1);
      add(0, 1, 0, 8'h02, 32'h88770201, 4'b0010, 0, 0, 2);
      // sync at slot 2
      add(0, 1, 1, 8'h99, 32'h88770299, 4'b0001, 0, 1, 1);
      // gapped valid then reset mid-frame
      add(0, 1, 0, 8'hA1, 32'h8877A199, 4'b0010, 0, 0, 2);
      add(0, 0, 0, 8'hB1, 32'h8877A199, 4'b0000, 0, 0, 2);
      add(0, 1, 0, 8'hA2, 32'h88A2A199, 4'b0100, 0, 0, 3);
      add(0, 0, 1, 8'hB0, 32'h88A2A199, 4'b0000, 0, 0, 3);
      add(1, 1, 1, 8'hC0, 32'h0, 4'b0000, 0, 0, 0);
      add(0, 1, 0, 8'hD0, 32'h0, 4'b0000, 0, 0, 0);
      // relock, then sync at slot 0 is not an error
      add(0, 1, 1, 8'hE0, 32'h000000E0, 4'b0001, 0, 0, 1);
      add(0, 1, 0, 8'hE1, 32'h0000E1E0, 4'b0010, 0, 0, 2);
      add(0, 1, 0, 8'hE2, 32'h00E2E1E0, 4'b0100, 0, 0, 3);
      add(0, 1, 0, 8'hE3, 32'hE3E2E1E0, 4'b1000, 1, 0, 0);
      add(0, 1, 1, 8'hF0, 32'hE3E2E1F0, 4'b0001, 0, 0, 1);

      foreach (tv[i]) begin
         step(tv[i].r, tv[i].v, tv[i].s, tv[i].d);
         chk("ch_data", i, ch_data, tv[i].cd);
         chk("ch_valid", i, {28'h0, ch_valid}, {28'h0, tv[i].cv});
         chk("frame_done", i, {31'h0, frame_done}, {31'h0, tv[i].fd});
         chk("sync_err", i, {31'h0, sync_err}, {31'h0, tv[i].se});
         chk("slot", i, {30'h0, slot}, {30'h0, tv[i].sl});
      end

      // idle gap: channels hold and strobes stay low
      for (int k = 0; k < 6; k++) begin
         step(0, 0, k[0], 8'h5A);
         chk("hold_data", k, ch_data, 32'hE3E2E1F0);
         chk("hold_valid", k, {28'h0, ch_valid}, 32'h0);
         chk("hold_slot", k, {30'h0, slot}, 32'h1);
      end

`ifdef TDM_DEMUX_FRAME_CNT_EN
      step(1, 0, 0, 8'h00);
      chk("fcnt_rst", 0, {16'h0, frame_cnt}, 32'h0);
      for (int f = 0; f < 3; f++) begin
         for (int w = 0; w < 4; w++) begin
            step(0, 1, w == 0, 8'(16 * f + w));
            if (w == 3) begin
               chk("fcnt_done", f, {31'h0, frame_done}, 32'h1);
               chk("fcnt", f, {16'h0, frame_cnt}, 32'(f + 1));
            end
         end
      end
      step(0, 1, 1, 8'h70);
      step(0, 1, 0, 8'h71);
      step(0, 1, 1, 8'h72);
      chk("fcnt_serr", 0, {31'h0, sync_err}, 32'h1);
      chk("fcnt_clr", 0, {16'h0, frame_cnt}, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
